riscv_pipe_reg: RTL and testbench
=================================

Name: riscv_pipe_reg

Overview:
Parametrised pipeline register stage, the successor to the plain enabled register. It carries a DW-bit payload between core pipeline stages using a valid/ready handshake, a synchronous flush and a configurable reset value. An optional two-entry skid buffer breaks the combinational ready path, so the stage sustains one transfer per cycle. It is used between IF/ID/EX/MEM/WB and on bus-side request paths.

Parameters:
DW, 32, payload width in bits (1..256).
RST_VAL, {DW{1'b0}}, value loaded into every data register on reset.
SKID, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.
FLUSH_CLR, 0, 1 = data registers load RST_VAL on flush; 0 = flush clears valid bits only.

Ports:
i_pipe_reg_clk  input  1  clock; all state updates on its rising edge.
i_pipe_reg_rstn  input  1  asynchronous active-low reset.
i_pipe_reg_valid  input  1  upstream payload valid.
i_pipe_reg_data  input  DW  upstream payload.
o_pipe_reg_ready  output  1  stage can accept upstream payload.
o_pipe_reg_valid  output  1  downstream payload valid.
o_pipe_reg_data  output  DW  downstream payload.
i_pipe_reg_ready  input  1  downstream accepts payload.
i_pipe_reg_flush  input  1  synchronous kill of all held payloads.
o_pipe_reg_level  output  2  entries held (0..2; at most 1 when SKID=0).

Behaviour:
- Reset is asynchronous and active-low. While i_pipe_reg_rstn=0: o_valid=0, o_data=RST_VAL, skid entry empty with data RST_VAL, o_level=0. o_ready is derived from state only, so it is 1 during reset. Upstream must not assert valid until reset is released.
- Transfer rules. An input transfer occurs on a rising edge where i_valid&o_ready=1. An output transfer occurs where o_valid&i_ready=1.
- While o_valid=1 and i_ready=0, o_data holds stable. A payload is never dropped, duplicated or reordered except by flush.
- SKID=1 state machine, with states EMPTY, ONE (main full) and TWO (main+skid full):
  - EMPTY: input transfer -> ONE with main<=i_data.
  - ONE, input only: if the output stalls -> TWO with skid<=i_data.
  - ONE, output only -> EMPTY.
  - ONE, input and output in the same cycle -> stay in ONE with main<=i_data.
  - TWO, output transfer -> ONE with main<=skid.
  - o_ready = (state!=TWO). This is a registered term, with no path from i_ready.
- SKID=0: a single entry with o_ready = !o_valid | i_ready (combinational).
  - Input transfer -> main<=i_data, o_valid<=1.
  - Output transfer without input -> o_valid<=0.
- Latency is 1 cycle from input transfer to o_valid, in both modes. Throughput is 1 transfer per cycle when i_ready=1 continuously.
- Flush:
  - When i_flush=1 at an edge, the next state is EMPTY, o_valid<=0 and o_level<=0.
  - Any input transfer in that same cycle is discarded.
  - An output transfer in that cycle still counts, because downstream has already sampled it.
  - If FLUSH_CLR=1, main and skid load RST_VAL.
  - Flush has priority over all handshake events.
- o_level = 0/1/2 for EMPTY/ONE/TWO; in SKID=0 it equals o_valid.
- Reset asserted mid-transfer: all entries are lost immediately, outputs return to their reset values asynchronously, and no partial state survives.
- Width rule: data is passed unmodified, with no sign extension or truncation; DW applies to every data register.

Decomposition:
- RST_VAL defaults and the pipeline payload widths (XLEN, instruction/PC widths) belong in the shared parameter include used by the core.
- State encoding localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) stay local to the block.
- One natural sub-module: riscv_pipe_reg_entry, a DW-bit register with asynchronous reset to RST_VAL, load enable and synchronous clear. It is instantiated for main and for skid (skid instantiated only when SKID=1).

Test Plan:
1. Reset: assert rstn=0 mid-stream with RST_VAL=32'hDEAD_BEEF -> o_valid=0, o_data=32'hDEADBEEF and o_level=0 immediately; o_ready=1.
2. Streaming: SKID=1, i_ready=1, send 0x1..0x10 on consecutive cycles -> same sequence out, one cycle later, 16 transfers in 16 cycles, o_level never exceeds 1.
3. Backpressure: SKID=1, send A=0xA, B=0xB, C=0xC back-to-back with i_ready=0.
   - A is accepted; B is accepted with o_level=2 and o_ready=0; C is held upstream.
   - o_data stays 0xA.
   - Release i_ready -> output is A, B, C in order with no loss.
4. Flush: hold two entries and, in the same cycle, assert flush with an input 0x55 -> next cycle o_valid=0, o_level=0 and 0x55 never appears. With FLUSH_CLR=1, o_data=RST_VAL.
5. SKID=0: with o_valid=1 and i_ready=0 -> o_ready=0; toggle i_ready=1 with a new input 0x77 in the same cycle -> o_data=0x77 next cycle and o_valid stays 1.
6. Random: valid/ready toggling at random over 10k cycles with DW=64 -> scoreboard matches exactly and o_level agrees with the model.

Source files
------------

// File: rtl/riscv_pipe_reg_pkg.sv
// Shared pipeline widths and payload reset defaults used by the core's stage registers.
package riscv_pipe_reg_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned PC_W = XLEN;

    localparam logic [XLEN-1:0] PIPE_RST_VAL = '0;

endpackage

// File: rtl/riscv_pipe_reg_entry.sv
// One DW-bit payload register: async reset and sync clear both load RST_VAL.
module riscv_pipe_reg_entry
    import riscv_pipe_reg_pkg::*;
#(
    parameter int unsigned     DW      = XLEN,
    parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/riscv_pipe_reg.sv
// Valid/ready pipeline stage with optional two-entry skid buffer and synchronous flush.
module riscv_pipe_reg
    import riscv_pipe_reg_pkg::*;
#(
    parameter int unsigned   DW        = XLEN,
    parameter logic [DW-1:0] RST_VAL   = {DW{1'b0}},
    parameter bit            SKID      = 1'b1,
    parameter bit            FLUSH_CLR = 1'b0
) (
    input  logic          i_pipe_reg_clk,
    input  logic          i_pipe_reg_rstn,
    input  logic          i_pipe_reg_valid,
    input  logic [DW-1:0] i_pipe_reg_data,
    output logic          o_pipe_reg_ready,
    output logic          o_pipe_reg_valid,
    output logic [DW-1:0] o_pipe_reg_data,
    input  logic          i_pipe_reg_ready,
    input  logic          i_pipe_reg_flush,
    output logic [1:0]    o_pipe_reg_level
);

    logic          ready;
    logic          valid;
    logic          in_xfer;
    logic          out_xfer;
    logic          clr;
    logic          main_load;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;

    // Flush discards the incoming payload; the outgoing one is already sampled downstream.
    assign in_xfer  = i_pipe_reg_valid & ready & ~i_pipe_reg_flush;
    assign out_xfer = valid & i_pipe_reg_ready;
    assign clr      = i_pipe_reg_flush & FLUSH_CLR;

    riscv_pipe_reg_entry #(
        .DW      (DW),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk   (i_pipe_reg_clk),
        .rst_n (i_pipe_reg_rstn),
        .load  (main_load),
        .clear (clr),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {
                StEmpty = 2'd0,
                StOne   = 2'd1,
                StTwo   = 2'd2
            } state_e;

            state_e        state;
            state_e        state_next;
            logic          skid_load;
            logic [DW-1:0] skid_q;

            riscv_pipe_reg_entry #(
                .DW      (DW),
                .RST_VAL (RST_VAL)
            ) u_skid (
                .clk   (i_pipe_reg_clk),
                .rst_n (i_pipe_reg_rstn),
                .load  (skid_load),
                .clear (clr),
                .d     (i_pipe_reg_data),
                .q     (skid_q)
            );

            always_ff @(posedge i_pipe_reg_clk or negedge i_pipe_reg_rstn) begin
                if (!i_pipe_reg_rstn) begin
                    state <= StEmpty;
                end else begin
                    state <= state_next;
                end
            end

            always_comb begin
                state_next = state;
                main_load  = 1'b0;
                skid_load  = 1'b0;
                main_d     = i_pipe_reg_data;
                case (state)
                    StEmpty: begin
                        if (in_xfer) begin
                            state_next = StOne;
                            main_load  = 1'b1;
                        end
                    end
                    StOne: begin
                        if (in_xfer && out_xfer) begin
                            main_load = 1'b1;
                        end else if (in_xfer) begin
                            state_next = StTwo;
                            skid_load  = 1'b1;
                        end else if (out_xfer) begin
                            state_next = StEmpty;
                        end
                    end
                    StTwo: begin
                        if (out_xfer) begin
                            state_next = StOne;
                            main_load  = 1'b1;
                            main_d     = skid_q;
                        end
                    end
                    default: state_next = StEmpty;
                endcase
                if (i_pipe_reg_flush) begin
                    state_next = StEmpty;
                    main_load  = 1'b0;
                    skid_load  = 1'b0;
                end
            end

            // Ready comes straight from the state register, never from downstream ready.
            assign ready            = (state != StTwo);
            assign valid            = (state != StEmpty);
            assign o_pipe_reg_level = state;
        end else begin : g_single
            logic valid_q;

            always_ff @(posedge i_pipe_reg_clk or negedge i_pipe_reg_rstn) begin
                if (!i_pipe_reg_rstn) begin
                    valid_q <= 1'b0;
                end else if (i_pipe_reg_flush) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign ready            = ~valid_q | i_pipe_reg_ready;
            assign valid            = valid_q;
            assign main_load        = in_xfer;
            assign main_d           = i_pipe_reg_data;
            assign o_pipe_reg_level = {1'b0, valid_q};
        end
    endgenerate

    assign o_pipe_reg_ready = ready;
    assign o_pipe_reg_valid = valid;
    assign o_pipe_reg_data  = main_q;

endmodule

// File: tb/tb_riscv_pipe_reg.sv
// Directed and randomized checks of riscv_pipe_reg in skid, single-entry and 64-bit forms.
module tb_riscv_pipe_reg;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // dut_a: SKID=1, FLUSH_CLR=1, nonzero reset value
    logic        a_valid = 0, a_ready = 0, a_flush = 0;
    logic [31:0] a_data = '0;
    logic        a_oready, a_ovalid;
    logic [31:0] a_odata;
    logic [1:0]  a_level;

    riscv_pipe_reg #(.DW(32), .RST_VAL(32'hDEAD_BEEF), .SKID(1'b1), .FLUSH_CLR(1'b1)) dut_a (
        .i_pipe_reg_clk(clk), .i_pipe_reg_rstn(rstn), .i_pipe_reg_valid(a_valid),
        .i_pipe_reg_data(a_data), .o_pipe_reg_ready(a_oready), .o_pipe_reg_valid(a_ovalid),
        .o_pipe_reg_data(a_odata), .i_pipe_reg_ready(a_ready), .i_pipe_reg_flush(a_flush),
        .o_pipe_reg_level(a_level)
    );

    // dut_b: SKID=0, FLUSH_CLR=0
    logic        b_valid = 0, b_ready = 0, b_flush = 0;
    logic [31:0] b_data = '0;
    logic        b_oready, b_ovalid;
    logic [31:0] b_odata;
    logic [1:0]  b_level;

    riscv_pipe_reg #(.DW(32), .RST_VAL(32'h0), .SKID(1'b0), .FLUSH_CLR(1'b0)) dut_b (
        .i_pipe_reg_clk(clk), .i_pipe_reg_rstn(rstn), .i_pipe_reg_valid(b_valid),
        .i_pipe_reg_data(b_data), .o_pipe_reg_ready(b_oready), .o_pipe_reg_valid(b_ovalid),
        .o_pipe_reg_data(b_odata), .i_pipe_reg_ready(b_ready), .i_pipe_reg_flush(b_flush),
        .o_pipe_reg_level(b_level)
    );

    // dut_c: SKID=1, DW=64, randomized traffic
    logic        c_valid = 0, c_ready = 0, c_flush = 0;
    logic [63:0] c_data = '0;
    logic        c_oready, c_ovalid;
    logic [63:0] c_odata;
    logic [1:0]  c_level;

    riscv_pipe_reg #(.DW(64), .RST_VAL(64'h0), .SKID(1'b1), .FLUSH_CLR(1'b0)) dut_c (
        .i_pipe_reg_clk(clk), .i_pipe_reg_rstn(rstn), .i_pipe_reg_valid(c_valid),
        .i_pipe_reg_data(c_data), .o_pipe_reg_ready(c_oready), .o_pipe_reg_valid(c_ovalid),
        .o_pipe_reg_data(c_odata), .i_pipe_reg_ready(c_ready), .i_pipe_reg_flush(c_flush),
        .o_pipe_reg_level(c_level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL rst_init_valid got=%0h exp=0", a_ovalid); end
        checks++; if (a_odata !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL rst_init_data got=%0h exp=deadbeef", a_odata); end
        checks++; if (b_odata !== 32'h0 || b_ovalid !== 1'b0) begin failures++;
            $display("FAIL rst_init_b got=%0h/%0h exp=0/0", b_odata, b_ovalid); end
        @(negedge clk); rstn = 1'b1;
        step();
        a_ready = 0; a_valid = 1; a_data = 32'h123;
        step();
        a_data = 32'h456;
        step();
        a_valid = 0;
        checks++; if (a_level !== 2'd2) begin failures++;
            $display("FAIL rst_prefill_level got=%0d exp=2", a_level); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL rst_mid_valid got=%0h exp=0", a_ovalid); end
        checks++; if (a_odata !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL rst_mid_data got=%0h exp=deadbeef", a_odata); end
        checks++; if (a_level !== 2'd0) begin failures++;
            $display("FAIL rst_mid_level got=%0d exp=0", a_level); end
        checks++; if (a_oready !== 1'b1) begin failures++;
            $display("FAIL rst_mid_ready got=%0h exp=1", a_oready); end
        @(negedge clk); rstn = 1'b1;
        step();
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL rst_release_valid got=%0h exp=0", a_ovalid); end
    endtask

    task automatic test_streaming();
        a_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            a_valid = 1; a_data = 32'(i);
            checks++; if (a_oready !== 1'b1) begin failures++;
                $display("FAIL stream_ready[%0d] got=%0h exp=1", i, a_oready); end
            step();
            checks++; if (a_ovalid !== 1'b1 || a_odata !== 32'(i) || a_level !== 2'd1) begin
                failures++;
                $display("FAIL stream_out[%0d] got v=%0h d=%0h l=%0d exp v=1 d=%0h l=1",
                         i, a_ovalid, a_odata, a_level, i);
            end
        end
        a_valid = 0;
        step();
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL stream_drain got=%0h exp=0", a_ovalid); end
    endtask

    task automatic test_backpressure();
        a_ready = 0; a_valid = 1; a_data = 32'hA;
        step();
        checks++; if (a_level !== 2'd1 || a_odata !== 32'hA) begin failures++;
            $display("FAIL bp_a got l=%0d d=%0h exp l=1 d=a", a_level, a_odata); end
        a_data = 32'hB;
        step();
        checks++; if (a_level !== 2'd2 || a_oready !== 1'b0 || a_odata !== 32'hA) begin
            failures++;
            $display("FAIL bp_b got l=%0d r=%0h d=%0h exp l=2 r=0 d=a",
                     a_level, a_oready, a_odata);
        end
        a_data = 32'hC;
        step();
        checks++; if (a_level !== 2'd2 || a_odata !== 32'hA) begin failures++;
            $display("FAIL bp_hold got l=%0d d=%0h exp l=2 d=a", a_level, a_odata); end
        a_ready = 1;
        step();
        checks++; if (a_odata !== 32'hB || a_level !== 2'd1 || a_oready !== 1'b1) begin
            failures++;
            $display("FAIL bp_out_b got d=%0h l=%0d r=%0h exp d=b l=1 r=1",
                     a_odata, a_level, a_oready);
        end
        step();
        checks++; if (a_odata !== 32'hC || a_level !== 2'd1) begin failures++;
            $display("FAIL bp_out_c got d=%0h l=%0d exp d=c l=1", a_odata, a_level); end
        a_valid = 0;
        step();
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL bp_drain got=%0h exp=0", a_ovalid); end
    endtask

    task automatic test_flush();
        a_ready = 0; a_valid = 1; a_data = 32'h11;
        step();
        a_data = 32'h22;
        step();
        a_data = 32'h55; a_flush = 1;
        step();
        checks++; if (a_ovalid !== 1'b0 || a_level !== 2'd0 || a_odata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL flush_two got v=%0h l=%0d d=%0h exp v=0 l=0 d=deadbeef",
                     a_ovalid, a_level, a_odata);
        end
        a_flush = 0; a_valid = 0; a_ready = 1;
        step();
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL flush_two_after got=%0h exp=0", a_ovalid); end
        a_ready = 0; a_valid = 1; a_data = 32'h11;
        step();
        a_data = 32'h55; a_flush = 1;
        step();
        checks++; if (a_ovalid !== 1'b0 || a_level !== 2'd0) begin failures++;
            $display("FAIL flush_one got v=%0h l=%0d exp v=0 l=0", a_ovalid, a_level); end
        a_flush = 0; a_valid = 0;
        step();
        checks++; if (a_ovalid !== 1'b0) begin failures++;
            $display("FAIL flush_one_after got=%0h exp=0", a_ovalid); end
        // FLUSH_CLR=0 keeps the stale payload but drops valid
        b_ready = 0; b_valid = 1; b_data = 32'h33;
        step();
        b_data = 32'h44; b_flush = 1;
        step();
        checks++; if (b_ovalid !== 1'b0 || b_odata !== 32'h33 || b_level !== 2'd0) begin
            failures++;
            $display("FAIL flush_noclr got v=%0h d=%0h l=%0d exp v=0 d=33 l=0",
                     b_ovalid, b_odata, b_level);
        end
        b_flush = 0; b_valid = 0;
        step();
        checks++; if (b_ovalid !== 1'b0) begin failures++;
            $display("FAIL flush_noclr_after got=%0h exp=0", b_ovalid); end
    endtask

    task automatic test_skid0();
        b_ready = 0; b_valid = 1; b_data = 32'h66;
        step();
        b_data = 32'h99;
        checks++; if (b_oready !== 1'b0 || b_ovalid !== 1'b1 || b_level !== 2'd1) begin
            failures++;
            $display("FAIL s0_stall got r=%0h v=%0h l=%0d exp r=0 v=1 l=1",
                     b_oready, b_ovalid, b_level);
        end
        step();
        checks++; if (b_odata !== 32'h66) begin failures++;
            $display("FAIL s0_hold got=%0h exp=66", b_odata); end
        b_ready = 1; b_data = 32'h77;
        #1;
        checks++; if (b_oready !== 1'b1) begin failures++;
            $display("FAIL s0_comb_ready got=%0h exp=1", b_oready); end
        step();
        checks++; if (b_odata !== 32'h77 || b_ovalid !== 1'b1) begin failures++;
            $display("FAIL s0_replace got d=%0h v=%0h exp d=77 v=1", b_odata, b_ovalid); end
        for (int i = 1; i <= 4; i++) begin
            b_data = 32'h100 + 32'(i);
            step();
            checks++; if (b_odata !== 32'h100 + 32'(i) || b_ovalid !== 1'b1) begin
                failures++;
                $display("FAIL s0_stream[%0d] got d=%0h v=%0h exp d=%0h v=1",
                         i, b_odata, b_ovalid, 32'h100 + 32'(i));
            end
        end
        b_valid = 0;
        step();
        checks++; if (b_ovalid !== 1'b0 || b_level !== 2'd0) begin failures++;
            $display("FAIL s0_drain got v=%0h l=%0d exp v=0 l=0", b_ovalid, b_level); end
        b_ready = 0;
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        in_x, out_x;
        int          errs = 0;
        for (int n = 0; n < 10000; n++) begin
            c_valid = 1'($urandom_range(0, 1));
            c_ready = 1'($urandom_range(0, 1));
            c_flush = ($urandom_range(0, 63) == 0);
            c_data  = {$urandom, $urandom};
            checks++;
            if (c_ovalid !== (q.size() != 0) || c_level !== 2'(q.size()) ||
                c_oready !== (q.size() != 2) || (q.size() != 0 && c_odata !== q[0])) begin
                failures++;
                if (errs < 10)
                    $display("FAIL rand[%0d] got v=%0h l=%0d r=%0h d=%0h exp l=%0d d=%0h",
                             n, c_ovalid, c_level, c_oready, c_odata, q.size(),
                             (q.size() != 0) ? q[0] : 64'h0);
                errs++;
            end
            in_x  = c_valid && (q.size() != 2);
            out_x = (q.size() != 0) && c_ready;
            step();
            if (out_x) void'(q.pop_front());
            if (c_flush) q.delete();
            else if (in_x) q.push_back(c_data);
        end
        c_valid = 0; c_flush = 0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
